// File: rtl/dom_blind_prng_if.sv
// dom_blind_prng_if
//   Seed handshake and blinding-output bundle of the DOM S-box PRNG.
//   master : seed producer / multiplier consumer side
//            (drives SeedxDI, SeedValidxSI, EnxSI)
//   slave  : the PRNG itself
//            (drives SeedReadyxSO, BxDO, ValidxSO)
//   OUT_W must equal the OUT_W derived inside dom_blind_prng.
interface dom_blind_prng_if #(
  parameter int OUT_W = 8
);
  logic [31:0]      SeedxDI;
  logic             SeedValidxSI;
  logic             SeedReadyxSO;
  logic             EnxSI;
  logic [OUT_W-1:0] BxDO;
  logic             ValidxSO;

  modport master (
    output SeedxDI, SeedValidxSI, EnxSI,
    input  SeedReadyxSO, BxDO, ValidxSO
  );

  modport slave (
    input  SeedxDI, SeedValidxSI, EnxSI,
    output SeedReadyxSO, BxDO, ValidxSO
  );
endinterface

// File: rtl/dom_blind_prng.sv
// dom_blind_prng
//   Fresh-randomness source for the masked GF(2^2) multipliers of the DOM
//   AES S-box. A 64-bit Fibonacci LFSR is seeded with two 32-bit words
//   (low word first), warmed up for WARMUP advances, then advanced by
//   OUT_W steps per consumer request. One output word feeds all NUM_MULT
//   multipliers; multiplier m takes BxDO[m*2*NRND +: 2*NRND].
//
// Ports
//   ClkxCI  : clock, rising edge
//   RstxBI  : asynchronous active-low reset
//   prng    : dom_blind_prng_if.slave
//             SeedxDI/SeedValidxSI/SeedReadyxSO  seed word handshake
//             EnxSI                              advance request
//             BxDO                               blinding bits
//             ValidxSO                           BxDO holds post-warmup randomness
//
// Build option
//   DOM_PRNG_ZERO_RND_EN : BxDO tied to zero and ValidxSO high from the first
//   clock after reset. The seed handshake still runs but has no effect on
//   the outputs. Intended for golden-vector runs without randomness.
//
// State table
//   state    | meaning
//   UNSEEDED | waiting for low seed word
//   SEED_HI  | waiting for high seed word
//   WARM     | discarding WARMUP advances, seed input blocked
//   RUN      | output valid, advancing on EnxSI, reseed allowed
module dom_blind_prng #(
  parameter int SHARES                   = 2,
  parameter int FIRST_ORDER_OPTIMIZATION = 1,
  parameter int NUM_MULT                 = 4,
  parameter int WARMUP                   = 16
) (
  input logic             ClkxCI,
  input logic             RstxBI,
  dom_blind_prng_if.slave prng
);

  localparam int NRND  = (FIRST_ORDER_OPTIMIZATION == 1 && SHARES == 2) ? SHARES - 1 : SHARES;
  localparam int OUT_W = NUM_MULT * 2 * NRND;
  localparam int WCW   = $clog2(WARMUP + 1);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP - 1);

  if (OUT_W > 64) begin : g_out_w_check
    $error("dom_blind_prng: OUT_W exceeds the 64-bit LFSR width");
  end
  if (SHARES < 2) begin : g_shares_check
    $error("dom_blind_prng: SHARES must be at least 2");
  end
  if (WARMUP < 1) begin : g_warmup_check
    $error("dom_blind_prng: WARMUP must be at least 1");
  end

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    SEED_HI  = 2'd1,
    WARM     = 2'd2,
    RUN      = 2'd3
  } state_t;

  state_t           state_q;
  logic [63:0]      lfsr_q;
  logic [OUT_W-1:0] bxd_q;
  logic             valid_q;
  logic             ready_q;
  logic [WCW-1:0]   warm_q;

  logic [63:0]      adv_s;
  logic [63:0]      seed_full_s;
  logic             seed_fire_s;

  // One advance: OUT_W LFSR steps unrolled into a single cycle.
  function automatic logic [63:0] advance(input logic [63:0] s);
    logic [63:0] t;
    logic        fb;
    t = s;
    for (int i = 0; i < OUT_W; i++) begin
      fb = t[63] ^ t[62] ^ t[60] ^ t[59];
      t  = {t[62:0], fb};
    end
    return t;
  endfunction

  assign adv_s       = advance(lfsr_q);
  assign seed_full_s = {prng.SeedxDI, lfsr_q[31:0]};
  assign seed_fire_s = prng.SeedValidxSI & ready_q;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q <= UNSEEDED;
      lfsr_q  <= '0;
      bxd_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      warm_q  <= '0;
    end else begin
      case (state_q)
        UNSEEDED: begin
          if (seed_fire_s) begin
            lfsr_q[31:0] <= prng.SeedxDI;
            state_q      <= SEED_HI;
          end
        end
        SEED_HI: begin
          if (seed_fire_s) begin
            // An all-zero state would lock the LFSR; substitute 1.
            lfsr_q  <= (seed_full_s == 64'h0) ? 64'h1 : seed_full_s;
            warm_q  <= '0;
            ready_q <= 1'b0;
            state_q <= WARM;
          end
        end
        WARM: begin
          lfsr_q <= adv_s;
          warm_q <= warm_q + 1'b1;
          if (warm_q == WARM_LAST) begin
            bxd_q   <= adv_s[OUT_W-1:0];
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // A reseed wins over a simultaneous advance request.
          if (seed_fire_s) begin
            lfsr_q[31:0] <= prng.SeedxDI;
            bxd_q        <= '0;
            valid_q      <= 1'b0;
            state_q      <= SEED_HI;
          end else if (prng.EnxSI && valid_q) begin
            lfsr_q <= adv_s;
            bxd_q  <= adv_s[OUT_W-1:0];
          end
        end
        default: begin
          state_q <= UNSEEDED;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign prng.SeedReadyxSO = ready_q;

`ifdef DOM_PRNG_ZERO_RND_EN
  logic zr_valid_q;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      zr_valid_q <= 1'b0;
    end else begin
      zr_valid_q <= 1'b1;
    end
  end

  assign prng.BxDO     = '0;
  assign prng.ValidxSO = zr_valid_q;
`else
  assign prng.BxDO     = bxd_q;
  assign prng.ValidxSO = valid_q;
`endif

endmodule
